// File: rtl/hidden_ram_arbiter.sv
// Round-robin arbiter for two writers and two readers sharing one external RAM,
// with a zero-fill sequencer that sweeps every entry after an i_clear pulse.
module hidden_ram_arbiter #(
  parameter int DW = 128,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_w0_req,
  input  logic          i_w1_req,
  input  logic [AW-1:0] i_w0_addr,
  input  logic [AW-1:0] i_w1_addr,
  input  logic [DW-1:0] i_w0_data,
  input  logic [DW-1:0] i_w1_data,
  output logic          o_w0_gnt,
  output logic          o_w1_gnt,
  input  logic          i_r0_req,
  input  logic          i_r1_req,
  input  logic [AW-1:0] i_r0_addr,
  input  logic [AW-1:0] i_r1_addr,
  output logic          o_r0_gnt,
  output logic          o_r1_gnt,
  output logic          o_r0_valid,
  output logic          o_r1_valid,
  output logic [DW-1:0] o_rdata,
  input  logic          i_clear,
  output logic          o_busy,
  output logic          o_ram_write,
  output logic          o_ram_read,
  output logic [AW-1:0] o_ram_addr_w,
  output logic [AW-1:0] o_ram_addr_r,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [AW-1:0] CNT_LAST = '1;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wp_q, wp_d;
  logic          rp_q, rp_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          r0_valid_q, r0_valid_d;
  logic          r1_valid_q, r1_valid_d;

  logic in_idle, in_clear;
  logic w0_gnt, w1_gnt, r0_gnt, r1_gnt;

  // Grants are masked by reset so nothing reaches the RAM while held in reset.
  always_comb begin
    in_idle  = i_reset_n && (state_q == ST_IDLE);
    in_clear = i_reset_n && (state_q == ST_CLEAR);

    w0_gnt = in_idle && i_w0_req && (!i_w1_req || !wp_q);
    w1_gnt = in_idle && i_w1_req && (!i_w0_req ||  wp_q);
    r0_gnt = i_reset_n && i_r0_req && (!i_r1_req || !rp_q);
    r1_gnt = i_reset_n && i_r1_req && (!i_r0_req ||  rp_q);

    o_ram_write  = w0_gnt || w1_gnt || in_clear;
    o_ram_addr_w = '0;
    o_ram_wdata  = '0;
    if (in_clear) begin
      o_ram_addr_w = cnt_q;
    end else if (w1_gnt) begin
      o_ram_addr_w = i_w1_addr;
      o_ram_wdata  = i_w1_data;
    end else if (w0_gnt) begin
      o_ram_addr_w = i_w0_addr;
      o_ram_wdata  = i_w0_data;
    end

    o_ram_read   = r0_gnt || r1_gnt;
    o_ram_addr_r = r1_gnt ? i_r1_addr : (r0_gnt ? i_r0_addr : '0);
  end

  always_comb begin
    wp_d = wp_q;
    if (w0_gnt)      wp_d = 1'b1;
    else if (w1_gnt) wp_d = 1'b0;

    rp_d = rp_q;
    if (r0_gnt)      rp_d = 1'b1;
    else if (r1_gnt) rp_d = 1'b0;

    rdata_d    = o_ram_read ? i_ram_rdata : rdata_q;
    r0_valid_d = r0_gnt;
    r1_valid_d = r1_gnt;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (i_clear) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      rdata_q    <= '0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      rdata_q    <= rdata_d;
      r0_valid_q <= r0_valid_d;
      r1_valid_q <= r1_valid_d;
    end
  end

  assign o_w0_gnt   = w0_gnt;
  assign o_w1_gnt   = w1_gnt;
  assign o_r0_gnt   = r0_gnt;
  assign o_r1_gnt   = r1_gnt;
  assign o_r0_valid = r0_valid_q;
  assign o_r1_valid = r1_valid_q;
  assign o_rdata    = rdata_q;
  assign o_busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_hidden_ram_arbiter.sv
// Directed bench for hidden_ram_arbiter with a behavioural 16-entry RAM
// (combinational read, write on the rising edge).
module tb_hidden_ram_arbiter;
  localparam int DW = 128;
  localparam int AW = 4;

  localparam logic [DW-1:0] DA = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
  localparam logic [DW-1:0] DB = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
  localparam logic [DW-1:0] DC = 128'hc0c0_c0c0_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] DD = 128'hdddd_0000_dddd_0000_dddd_0000_dddd_0009;
  localparam logic [DW-1:0] DE = 128'h0eee_eeee_eeee_eeee_eeee_eeee_eeee_eee2;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_w0_req, i_w1_req;
  logic [AW-1:0] i_w0_addr, i_w1_addr;
  logic [DW-1:0] i_w0_data, i_w1_data;
  logic          o_w0_gnt, o_w1_gnt;
  logic          i_r0_req, i_r1_req;
  logic [AW-1:0] i_r0_addr, i_r1_addr;
  logic          o_r0_gnt, o_r1_gnt;
  logic          o_r0_valid, o_r1_valid;
  logic [DW-1:0] o_rdata;
  logic          i_clear;
  logic          o_busy;
  logic          o_ram_write, o_ram_read;
  logic [AW-1:0] o_ram_addr_w, o_ram_addr_r;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  logic [DW-1:0] mem [16];

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_ram_write) mem[o_ram_addr_w] <= o_ram_wdata;
  assign i_ram_rdata = o_ram_read ? mem[o_ram_addr_r] : '0;

  hidden_ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_w0_req(i_w0_req), .i_w1_req(i_w1_req),
    .i_w0_addr(i_w0_addr), .i_w1_addr(i_w1_addr),
    .i_w0_data(i_w0_data), .i_w1_data(i_w1_data),
    .o_w0_gnt(o_w0_gnt), .o_w1_gnt(o_w1_gnt),
    .i_r0_req(i_r0_req), .i_r1_req(i_r1_req),
    .i_r0_addr(i_r0_addr), .i_r1_addr(i_r1_addr),
    .o_r0_gnt(o_r0_gnt), .o_r1_gnt(o_r1_gnt),
    .o_r0_valid(o_r0_valid), .o_r1_valid(o_r1_valid),
    .o_rdata(o_rdata), .i_clear(i_clear), .o_busy(o_busy),
    .o_ram_write(o_ram_write), .o_ram_read(o_ram_read),
    .o_ram_addr_w(o_ram_addr_w), .o_ram_addr_r(o_ram_addr_r),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_w0_req = 0; i_w1_req = 0; i_r0_req = 0; i_r1_req = 0; i_clear = 0;
    i_w0_addr = '0; i_w1_addr = '0; i_r0_addr = '0; i_r1_addr = '0;
    i_w0_data = '0; i_w1_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_reset_n = 0;
    i_w0_req = 1; i_w1_req = 1; i_r0_req = 1; i_r1_req = 1; i_clear = 1;
    repeat (3) step();
    checks++;
    if ({o_w0_gnt, o_w1_gnt, o_r0_gnt, o_r1_gnt, o_ram_write, o_ram_read} !== 6'b0) begin
      failures++;
      $display("FAIL reset_grants got=%b exp=000000",
               {o_w0_gnt, o_w1_gnt, o_r0_gnt, o_r1_gnt, o_ram_write, o_ram_read});
    end
    checks++;
    if ({o_busy, o_r0_valid, o_r1_valid} !== 3'b0 || o_rdata !== '0) begin
      failures++;
      $display("FAIL reset_state busy/v0/v1=%b rdata=%h exp 000 / 0",
               {o_busy, o_r0_valid, o_r1_valid}, o_rdata);
    end
    idle_inputs();
  endtask

  task automatic test_write_rr();
    logic exp0;
    // release reset mid-cycle; both writers may be granted straight away
    i_reset_n = 1;
    i_w0_req = 1; i_w0_addr = 4'd3; i_w0_data = DA;
    i_w1_req = 1; i_w1_addr = 4'd5; i_w1_data = DB;
    for (int c = 0; c < 4; c++) begin
      #1;
      exp0 = (c % 2 == 0);
      checks++;
      if (o_w0_gnt !== exp0 || o_w1_gnt !== !exp0) begin
        failures++;
        $display("FAIL wr_rr_gnt c%0d got=%b%b exp=%b%b", c, o_w0_gnt, o_w1_gnt, exp0, !exp0);
      end
      checks++;
      if (o_ram_write !== 1'b1 || o_ram_addr_w !== (exp0 ? 4'd3 : 4'd5) ||
          o_ram_wdata !== (exp0 ? DA : DB)) begin
        failures++;
        $display("FAIL wr_rr_port c%0d got we=%b a=%0d exp a=%0d", c, o_ram_write,
                 o_ram_addr_w, exp0 ? 3 : 5);
      end
      step();
    end
    i_w0_req = 0;
    i_w1_addr = 4'd9; i_w1_data = DD;
    #1;
    checks++;
    if (o_w1_gnt !== 1'b1 || o_w0_gnt !== 1'b0 || o_ram_addr_w !== 4'd9) begin
      failures++;
      $display("FAIL wr_single got=%b%b a=%0d exp=01 a=9", o_w0_gnt, o_w1_gnt, o_ram_addr_w);
    end
    step();
    i_w1_req = 0;
    #1;
    checks++;
    if (mem[3] !== DA || mem[5] !== DB || mem[9] !== DD) begin
      failures++;
      $display("FAIL wr_mem got m3=%h m5=%h m9=%h", mem[3], mem[5], mem[9]);
    end
    checks++;
    if (o_ram_write !== 1'b0 || o_w0_gnt !== 1'b0 || o_w1_gnt !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle got we=%b exp=0", o_ram_write);
    end
  endtask

  task automatic test_read_rr();
    i_r0_req = 1; i_r0_addr = 4'd3;
    i_r1_req = 1; i_r1_addr = 4'd5;
    #1;
    checks++;
    if (o_r0_gnt !== 1'b1 || o_r1_gnt !== 1'b0 || o_ram_read !== 1'b1 || o_ram_addr_r !== 4'd3) begin
      failures++;
      $display("FAIL rd_n got=%b%b rd=%b a=%0d exp=10 1 3", o_r0_gnt, o_r1_gnt, o_ram_read, o_ram_addr_r);
    end
    step();
    i_r0_req = 0;
    #1;
    checks++;
    if (o_rdata !== DA || o_r0_valid !== 1'b1 || o_r1_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_n1_data got=%h v=%b%b exp=%h v=10", o_rdata, o_r0_valid, o_r1_valid, DA);
    end
    checks++;
    if (o_r1_gnt !== 1'b1 || o_ram_addr_r !== 4'd5) begin
      failures++;
      $display("FAIL rd_n1_gnt got=%b a=%0d exp=1 a=5", o_r1_gnt, o_ram_addr_r);
    end
    step();
    i_r1_req = 0;
    #1;
    checks++;
    if (o_rdata !== DB || o_r0_valid !== 1'b0 || o_r1_valid !== 1'b1) begin
      failures++;
      $display("FAIL rd_n2_data got=%h v=%b%b exp=%h v=01", o_rdata, o_r0_valid, o_r1_valid, DB);
    end
    step();
    checks++;
    if (o_rdata !== DB || o_r0_valid !== 1'b0 || o_r1_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_hold got=%h v=%b%b exp=%h v=00", o_rdata, o_r0_valid, o_r1_valid, DB);
    end
  endtask

  task automatic test_clear();
    i_clear = 1;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_start_busy got=%b exp=0", o_busy);
    end
    step();
    i_clear = 0;
    i_w0_req = 1; i_w0_addr = 4'd2; i_w0_data = DE;
    for (int c = 0; c < 16; c++) begin
      i_clear = (c == 8);
      #1;
      checks++;
      if (o_busy !== 1'b1 || o_w0_gnt !== 1'b0 || o_ram_write !== 1'b1 ||
          o_ram_addr_w !== 4'(c) || o_ram_wdata !== '0) begin
        failures++;
        $display("FAIL clr_fill c%0d got busy=%b g=%b we=%b a=%0d exp 1 0 1 a=%0d",
                 c, o_busy, o_w0_gnt, o_ram_write, o_ram_addr_w, c);
      end
      step();
    end
    i_clear = 0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_w0_gnt !== 1'b1 || o_ram_addr_w !== 4'd2 || o_ram_wdata !== DE) begin
      failures++;
      $display("FAIL clr_after got busy=%b g=%b a=%0d exp 0 1 a=2", o_busy, o_w0_gnt, o_ram_addr_w);
    end
    step();
    i_w0_req = 0;
    i_r0_req = 1;
    for (int a = 0; a < 16; a++) begin
      i_r0_addr = 4'(a);
      step();
      checks++;
      if (o_r0_valid !== 1'b1 || o_rdata !== ((a == 2) ? DE : '0)) begin
        failures++;
        $display("FAIL clr_readback a%0d got=%h v=%b", a, o_rdata, o_r0_valid);
      end
    end
    i_r0_req = 0;
  endtask

  task automatic test_same_addr();
    i_w0_req = 1; i_w0_addr = 4'd7; i_w0_data = DC;
    i_r0_req = 1; i_r0_addr = 4'd7;
    #1;
    checks++;
    if (o_w0_gnt !== 1'b1 || o_r0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL same_gnt got w=%b r=%b exp 1 1", o_w0_gnt, o_r0_gnt);
    end
    step();
    i_w0_req = 0;
    #1;
    checks++;
    if (o_rdata !== '0 || o_r0_valid !== 1'b1) begin
      failures++;
      $display("FAIL same_prewrite got=%h v=%b exp=0 v=1", o_rdata, o_r0_valid);
    end
    step();
    i_r0_req = 0;
    checks++;
    if (o_rdata !== DC) begin
      failures++;
      $display("FAIL same_next got=%h exp=%h", o_rdata, DC);
    end
  endtask

  task automatic test_clear_reset();
    i_w0_req = 1;
    for (int a = 8; a < 16; a++) begin
      i_w0_addr = 4'(a); i_w0_data = DW'(256 + a);
      step();
    end
    // clear and a write together: write wins this cycle, fill starts next
    i_clear = 1; i_w0_addr = 4'd8; i_w0_data = DW'(264);
    #1;
    checks++;
    if (o_w0_gnt !== 1'b1 || o_busy !== 1'b0 || o_ram_addr_w !== 4'd8) begin
      failures++;
      $display("FAIL clr_with_write got g=%b busy=%b a=%0d exp 1 0 8", o_w0_gnt, o_busy, o_ram_addr_w);
    end
    step();
    i_clear = 0; i_w0_req = 0;
    for (int c = 0; c < 8; c++) step();
    checks++;
    if (o_busy !== 1'b1 || o_ram_addr_w !== 4'd8) begin
      failures++;
      $display("FAIL clr_cnt8 got busy=%b a=%0d exp 1 8", o_busy, o_ram_addr_w);
    end
    i_reset_n = 0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_ram_write !== 1'b0) begin
      failures++;
      $display("FAIL clr_abort got busy=%b we=%b exp 0 0", o_busy, o_ram_write);
    end
    step();
    step();
    i_reset_n = 1;
    i_r0_req = 1;
    for (int a = 0; a < 16; a++) begin
      i_r0_addr = 4'(a);
      step();
      checks++;
      if (o_r0_valid !== 1'b1 || o_rdata !== ((a < 8) ? '0 : DW'(256 + a))) begin
        failures++;
        $display("FAIL abort_readback a%0d got=%h v=%b", a, o_rdata, o_r0_valid);
      end
    end
    i_r0_req = 0;
  endtask

  initial begin
    test_reset();
    test_write_rr();
    test_read_rr();
    test_clear();
    test_same_addr();
    test_clear_reset();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
